uart_rx_fifo: RTL and testbench

Parametrised UART receiver with a buffered output, the next generation of the `uart_top` receive path. It deserialises an asynchronous `ser_rx` line at a configurable bit period and data width, with optional parity. Completed words enter a FIFO with a valid/ready output port, and framing, parity and overflow errors are reported as pulses. It sits between the board's serial pin and any consumer that cannot accept a word on every frame.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_fifo.sv | 48 ++++
 rtl/uart_rx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Pure declarations; no logic, no latency, no backpressure.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;

  // fifo_count must represent 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Circular-buffer FIFO; write visible on valid/count one cycle after push.
// Push while full is accepted only together with a pop; pop while empty is ignored.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  output logic                           valid_o,
  output logic [WIDTH-1:0]               data_o,
  output logic [count_width(DEPTH)-1:0]  count_o,
  output logic                           full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign valid_o = (wr_ptr_q != rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver feeding a valid/ready FIFO; word visible one cycle after the stop sample.
// Optional even parity bit under `UART_RX_PARITY_EN; a full FIFO without a pop drops the word.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 3,
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ser_rx,
  output logic [DATA_BITS-1:0]                out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [count_width(FIFO_DEPTH)-1:0]  fifo_count,
  output logic                                err_frame,
  output logic                                err_parity,
  output logic                                err_overflow
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int SW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST = SW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        bitn_q, bitn_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 armed_q, armed_d;
  logic                 err_frame_q, err_frame_d;
  logic                 err_ovf_q;
  logic                 push_req, pop, fifo_full;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q, par_err_d;
  logic                 err_par_q, err_par_d;
`endif

  assign pop = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitn_d      = bitn_q;
    shreg_d     = shreg_q;
    armed_d     = armed_q;
    err_frame_d = 1'b0;
    push_req    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
    err_par_d   = 1'b0;
`endif
    case (state_q)
      // armed_q is cleared by a framing error so a held-low break waits for a new falling edge
      IDLE: begin
        cnt_d  = '0;
        bitn_d = '0;
`ifdef UART_RX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (sync2_q == LINE_IDLE) armed_d = 1'b1;
        else if (armed_q)         state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = (sync2_q == LINE_IDLE) ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
          if (bitn_q == BIT_LAST) begin
            bitn_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitn_d = bitn_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = STOP;
          if (sync2_q != ^shreg_q) begin
            par_err_d = 1'b1;
            err_par_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sync2_q != LINE_IDLE) begin
            err_frame_d = 1'b1;
            armed_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
          end else if (!par_err_q) begin
`else
          end else begin
`endif
            push_req = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= LINE_IDLE;
      sync2_q     <= LINE_IDLE;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      shreg_q     <= '0;
      armed_q     <= 1'b1;
      err_frame_q <= 1'b0;
      err_ovf_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
      err_par_q   <= 1'b0;
`endif
    end else begin
      sync1_q     <= ser_rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitn_q      <= bitn_d;
      shreg_q     <= shreg_d;
      armed_q     <= armed_d;
      err_frame_q <= err_frame_d;
      err_ovf_q   <= push_req && fifo_full && !pop;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
      err_par_q   <= err_par_d;
`endif
    end
  end

  assign err_frame    = err_frame_q;
  assign err_overflow = err_ovf_q;
`ifdef UART_RX_PARITY_EN
  assign err_parity   = err_par_q;
`else
  assign err_parity   = 1'b0;
`endif

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_req),
    .push_data_i (shreg_q),
    .pop_i       (pop),
    .valid_o     (out_valid),
    .data_o      (out_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLOCKS_PER_BIT=3, DATA_BITS=8, FIFO_DEPTH=4.
module tb_uart_rx_fifo;

  localparam int C = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_rx = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_count;
  logic       err_frame, err_parity, err_overflow;

  int checks = 0;
  int failures = 0;
  int ef = 0, ep = 0, eo = 0;
`ifdef UART_RX_PARITY_EN
  logic bad_par = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLOCKS_PER_BIT (C),
    .DATA_BITS      (8),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ser_rx       (ser_rx),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_count   (fifo_count),
    .err_frame    (err_frame),
    .err_parity   (err_parity),
    .err_overflow (err_overflow)
  );

  // pulse tallies, one count per cycle high
  always @(negedge clk) begin
    if (err_frame)    ef++;
    if (err_parity)   ep++;
    if (err_overflow) eo++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    ser_rx = 1'b0;
    tick_n(C);
    for (int i = 0; i < 8; i++) begin
      ser_rx = d[i];
      tick_n(C);
    end
`ifdef UART_RX_PARITY_EN
    ser_rx = (^d) ^ bad_par;
    tick_n(C);
`endif
    ser_rx = stop_b;
    tick_n(C);
    ser_rx = 1'b1;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick_n(1);
    out_ready = 1'b0;
  endtask

  task automatic check_errs(input string tag, input int xf, input int xp, input int xo);
    check({tag, "_frame_pulses"}, ef, xf);
    check({tag, "_parity_pulses"}, ep, xp);
    check({tag, "_ovf_pulses"}, eo, xo);
  endtask

  initial begin
    tick_n(3);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_errs", 32'({err_frame, err_parity, err_overflow}), 32'd0);
    rst = 1'b0;
    tick_n(4);

    // single frame: stop sample on the edge after the last driven cycle
    send_frame(8'h48, 1'b1);
    @(negedge clk);
    check("single_valid_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'h48);
    check("single_count", 32'(fifo_count), 32'd1);
    pop_one();
    @(negedge clk);
    check("single_pop_count", 32'(fifo_count), 32'd0);
    check("single_pop_valid", 32'(out_valid), 32'd0);
    check_errs("single", 0, 0, 0);

    // five back-to-back frames into a 4-deep FIFO
    tick_n(2);
    for (int i = 0; i < 5; i++) send_frame(8'(8'h41 + i), 1'b1);
    tick_n(3);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check_errs("ovf", 0, 0, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data", 32'(out_data), 32'(32'h41 + i));
    end
    tick_n(1);
    out_ready = 1'b0;
    @(negedge clk);
    check("drain_count", 32'(fifo_count), 32'd0);
    check("drain_valid_end", 32'(out_valid), 32'd0);

    // stop bit low
    tick_n(2);
    send_frame(8'h55, 1'b0);
    tick_n(4);
    check("frame_count", 32'(fifo_count), 32'd0);
    check_errs("frame", 1, 0, 1);
    send_frame(8'hAA, 1'b1);
    tick_n(2);
    check("after_frame_count", 32'(fifo_count), 32'd1);
    check("after_frame_data", 32'(out_data), 32'hAA);
    pop_one();

    // held-low break: one framing error then silence
    ser_rx = 1'b0;
    tick_n(20 * C);
    ser_rx = 1'b1;
    tick_n(6);
    check("break_count", 32'(fifo_count), 32'd0);
    check_errs("break", 2, 0, 1);

    // one-cycle glitch on idle line
    ser_rx = 1'b0;
    tick_n(1);
    ser_rx = 1'b1;
    tick_n(40);
    check("glitch_count", 32'(fifo_count), 32'd0);
    check("glitch_valid", 32'(out_valid), 32'd0);
    check_errs("glitch", 2, 0, 1);

`ifdef UART_RX_PARITY_EN
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1);
    tick_n(4);
    check("par_bad_count", 32'(fifo_count), 32'd0);
    check_errs("par_bad", 2, 1, 1);
    bad_par = 1'b0;
    send_frame(8'h07, 1'b1);
    tick_n(2);
    check("par_good_count", 32'(fifo_count), 32'd1);
    check("par_good_data", 32'(out_data), 32'h07);
    pop_one();
    check_errs("par_good", 2, 1, 1);
`endif

    // reset mid-data-bit with a word already buffered
    send_frame(8'h33, 1'b1);
    tick_n(2);
    check("pre_rst_count", 32'(fifo_count), 32'd1);
    ser_rx = 1'b0;
    tick_n(C);
    ser_rx = 1'b1;
    tick_n(C);
    ser_rx = 1'b0;
    tick_n(1);
    rst = 1'b1;
    ser_rx = 1'b1;
    tick_n(1);
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_errs", 32'({err_frame, err_parity, err_overflow}), 32'd0);
    tick_n(1);
    rst = 1'b0;
    tick_n(5);
    send_frame(8'h5A, 1'b1);
    tick_n(2);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data", 32'(out_data), 32'h5A);
    check("post_rst_count", 32'(fifo_count), 32'd1);
    tick_n(4);
`ifdef UART_RX_PARITY_EN
    check_errs("final", 2, 1, 1);
`else
    check_errs("final", 2, 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
